// File: rtl/aibcr3_str_pkg.sv
// Shared types and helpers for the strobe DLL lock controller.
// Holds the sequencer state encoding, the default code width and Gray/divider helpers.
package aibcr3_str_pkg;

    localparam int CODE_W_DEF = 11;
    localparam int GRAY_MAX_W = 16;
    localparam int DIV_W      = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } str_state_e;

    // Callers zero-extend into the wide argument and cast the result back to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Terminal count of the tick divider: 2^(sel+3)-1, i.e. 7..1023.
    function automatic logic [DIV_W-1:0] div_term(input logic [2:0] sel);
        logic [DIV_W:0] period;
        period = {{DIV_W{1'b0}}, 1'b1} << ({1'b0, sel} + 4'd3);
        return DIV_W'(period - {{DIV_W{1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/aibcr3_str_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
// Used for the phase-detector up/down inputs, which are asynchronous to the reference clock.
module aibcr3_str_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/aibcr3_str_lock_ctrl.sv
// Strobe DLL lock controller: steps a saturating delay code from phase-detector votes
// on divided ticks, declares lock after enough direction reversals, drives Gray codes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for lock_req; code, reversal count, divider held
// ST_INIT   | one cycle: load INIT_CODE, clear divider/reversals/sat
// ST_TRACK  | step code on each tick, count direction reversals
// ST_LOCKED | lock declared; keep stepping only if rb_selflock
module aibcr3_str_lock_ctrl
    import aibcr3_str_pkg::*;
#(
    parameter int                CODE_W    = CODE_W_DEF,
    parameter int                LOCK_CNT  = 4,
    parameter logic [CODE_W-1:0] INIT_CODE = '0
) (
    input  logic              clk_pll,
    input  logic              str_rst_n,
    input  logic              t_up,
    input  logic              t_down,
    input  logic              lock_req,
    input  logic [2:0]        rb_clkdiv,
    input  logic              rb_selflock,
    output logic              dll_phdet_reset_n,
    output logic [CODE_W-4:0] f_gray,
    output logic [2:0]        i_gray,
    output logic [CODE_W-1:0] pvt_ref_gry,
    output logic [CODE_W-1:0] pvt_ref_half_gry,
    output logic              code_valid,
    output logic              dll_lock,
    output logic              sat
);

    localparam int REV_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
    localparam logic [REV_W-1:0]  REV_ONE  = REV_W'(1);
    localparam logic [REV_W-1:0]  REV_LOCK = REV_W'(LOCK_CNT);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    logic up_s;
    logic dn_s;

    aibcr3_str_sync2 u_sync_up (
        .clk_i   (clk_pll),
        .rst_n_i (str_rst_n),
        .d_i     (t_up),
        .q_o     (up_s)
    );

    aibcr3_str_sync2 u_sync_dn (
        .clk_i   (clk_pll),
        .rst_n_i (str_rst_n),
        .d_i     (t_down),
        .q_o     (dn_s)
    );

    str_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              dir_up_q, dir_up_d;
    logic              have_dir_q, have_dir_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  lim_q, lim_d;
    logic              sat_q, sat_d;

    logic              phdet_q, valid_q, lock_q;
    logic [CODE_W-4:0] f_gray_q;
    logic [2:0]        i_gray_q;
    logic [CODE_W-1:0] gry_q, half_gry_q;

    logic              tick;
    logic              want_up;
    logic              want_dn;
    logic              active;
    logic              push_sat;
    logic              step;
    logic              reversal;
    logic [REV_W-1:0]  rev_inc;

    always_comb begin
        tick     = ((state_q == ST_TRACK) || (state_q == ST_LOCKED)) && (div_q == lim_q);
        want_up  = up_s & ~dn_s;
        want_dn  = dn_s & ~up_s;
        active   = tick && ((state_q == ST_TRACK) || rb_selflock);
        push_sat = active && ((want_up && (code_q == CODE_MAX)) ||
                              (want_dn && (code_q == '0)));
        step     = active && (want_up || want_dn) && !push_sat;
        // A reversal is only meaningful against an earlier real step since INIT.
        reversal = step && (state_q == ST_TRACK) && have_dir_q && (dir_up_q != want_up);
        rev_inc  = rev_q + REV_ONE;

        state_d    = state_q;
        code_d     = code_q;
        rev_d      = rev_q;
        dir_up_d   = dir_up_q;
        have_dir_d = have_dir_q;
        div_d      = div_q;
        lim_d      = lim_q;
        sat_d      = sat_q;

        if (!lock_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_INIT;
                end
                ST_INIT: begin
                    code_d     = INIT_CODE;
                    rev_d      = '0;
                    dir_up_d   = 1'b0;
                    have_dir_d = 1'b0;
                    div_d      = '0;
                    lim_d      = div_term(rb_clkdiv);
                    sat_d      = 1'b0;
                    state_d    = ST_TRACK;
                end
                ST_TRACK, ST_LOCKED: begin
                    if (tick) begin
                        div_d = '0;
                        lim_d = div_term(rb_clkdiv);
                        sat_d = push_sat;
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                    if (step) begin
                        code_d = want_up ? (code_q + CODE_ONE) : (code_q - CODE_ONE);
                        if (state_q == ST_TRACK) begin
                            dir_up_d   = want_up;
                            have_dir_d = 1'b1;
                            if (reversal) begin
                                rev_d = rev_inc;
                                if (rev_inc == REV_LOCK) state_d = ST_LOCKED;
                            end else if (have_dir_q) begin
                                rev_d = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pll or negedge str_rst_n) begin
        if (!str_rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= INIT_CODE;
            rev_q      <= '0;
            dir_up_q   <= 1'b0;
            have_dir_q <= 1'b0;
            div_q      <= '0;
            lim_q      <= '0;
            sat_q      <= 1'b0;
            phdet_q    <= 1'b0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            f_gray_q   <= '0;
            i_gray_q   <= '0;
            gry_q      <= '0;
            half_gry_q <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            rev_q      <= rev_d;
            dir_up_q   <= dir_up_d;
            have_dir_q <= have_dir_d;
            div_q      <= div_d;
            lim_q      <= lim_d;
            sat_q      <= sat_d;
            // Outputs are registered from next-state so they move on the same edge as the code.
            phdet_q    <= (state_d == ST_TRACK) || (state_d == ST_LOCKED);
            valid_q    <= (state_d == ST_TRACK) || (state_d == ST_LOCKED);
            lock_q     <= (state_d == ST_LOCKED);
            f_gray_q   <= (CODE_W-3)'(bin2gray(GRAY_MAX_W'(code_d[CODE_W-1:3])));
            i_gray_q   <= 3'(bin2gray(GRAY_MAX_W'(code_d[2:0])));
            gry_q      <= CODE_W'(bin2gray(GRAY_MAX_W'(code_d)));
            half_gry_q <= CODE_W'(bin2gray(GRAY_MAX_W'(code_d >> 1)));
        end
    end

    assign dll_phdet_reset_n = phdet_q;
    assign code_valid        = valid_q;
    assign dll_lock          = lock_q;
    assign sat               = sat_q;
    assign f_gray            = f_gray_q;
    assign i_gray            = i_gray_q;
    assign pvt_ref_gry       = gry_q;
    assign pvt_ref_half_gry  = half_gry_q;

endmodule

// File: tb/tb_aibcr3_str_lock_ctrl.sv
// Self-checking bench for aibcr3_str_lock_ctrl: vector table, directed corner
// sequences and randomized ticks against a per-tick behavioural model.
module tb_aibcr3_str_lock_ctrl;

    localparam int LOCK_CNT = 4;
    localparam int CODE_MAX = 2047;

    logic        clk_pll = 1'b0;
    logic        str_rst_n;
    logic        t_up;
    logic        t_down;
    logic        lock_req;
    logic [2:0]  rb_clkdiv;
    logic        rb_selflock;
    logic        dll_phdet_reset_n;
    logic [7:0]  f_gray;
    logic [2:0]  i_gray;
    logic [10:0] pvt_ref_gry;
    logic [10:0] pvt_ref_half_gry;
    logic        code_valid;
    logic        dll_lock;
    logic        sat;

    always #5 clk_pll = ~clk_pll;

    aibcr3_str_lock_ctrl #(
        .CODE_W    (11),
        .LOCK_CNT  (LOCK_CNT),
        .INIT_CODE (11'd0)
    ) dut (
        .clk_pll           (clk_pll),
        .str_rst_n         (str_rst_n),
        .t_up              (t_up),
        .t_down            (t_down),
        .lock_req          (lock_req),
        .rb_clkdiv         (rb_clkdiv),
        .rb_selflock       (rb_selflock),
        .dll_phdet_reset_n (dll_phdet_reset_n),
        .f_gray            (f_gray),
        .i_gray            (i_gray),
        .pvt_ref_gry       (pvt_ref_gry),
        .pvt_ref_half_gry  (pvt_ref_half_gry),
        .code_valid        (code_valid),
        .dll_lock          (dll_lock),
        .sat               (sat)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, advanced once per divider tick.
    int m_code;
    int m_rev;
    int m_prev;
    bit m_locked;
    bit m_sat;
    int period;

    typedef struct {
        bit up;
        bit dn;
        bit sl;
        int code;
        bit sat;
        bit lock;
    } vec_t;

    vec_t tbl[20];

    function automatic int gray_of(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_code(input string tag, input int code);
        chk({tag, "_pvt_gry"}, int'(pvt_ref_gry), gray_of(code));
        chk({tag, "_half_gry"}, int'(pvt_ref_half_gry), gray_of(code >> 1));
        chk({tag, "_f_gray"}, int'(f_gray), gray_of(code >> 3));
        chk({tag, "_i_gray"}, int'(i_gray), gray_of(code & 7));
    endtask

    task automatic check_status(input string tag, input bit e_sat, input bit e_lock, input bit e_run);
        chk({tag, "_sat"}, int'(sat), int'(e_sat));
        chk({tag, "_dll_lock"}, int'(dll_lock), int'(e_lock));
        chk({tag, "_code_valid"}, int'(code_valid), int'(e_run));
        chk({tag, "_phdet_rst_n"}, int'(dll_phdet_reset_n), int'(e_run));
    endtask

    function automatic void model_reset();
        m_code   = 0;
        m_rev    = 0;
        m_prev   = 0;
        m_locked = 1'b0;
        m_sat    = 1'b0;
    endfunction

    function automatic void model_tick(input bit up, input bit dn, input bit sl);
        int dir;
        dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if ((m_locked && !sl) || dir == 0) begin
            m_sat = 1'b0;
            return;
        end
        if (m_code + dir < 0 || m_code + dir > CODE_MAX) begin
            m_sat = 1'b1;
            return;
        end
        m_sat  = 1'b0;
        m_code = m_code + dir;
        if (!m_locked) begin
            if (m_prev != 0) m_rev = (dir != m_prev) ? m_rev + 1 : 0;
            m_prev = dir;
            if (m_rev == LOCK_CNT) m_locked = 1'b1;
        end
    endfunction

    // Drive votes right after the previous tick, confirm the code has not moved one
    // cycle early, then clock through the tick edge.
    task automatic run_tick(input bit up, input bit dn, input bit sl, input int per, input int held);
        t_up        = up;
        t_down      = dn;
        rb_selflock = sl;
        repeat (per - 1) step();
        chk("pre_tick_code", int'(pvt_ref_gry), gray_of(held));
        step();
    endtask

    task automatic model_step(input bit up, input bit dn, input bit sl);
        run_tick(up, dn, sl, period, m_code);
        model_tick(up, dn, sl);
        check_code("tick", m_code);
        check_status("tick", m_sat, m_locked, 1'b1);
    endtask

    task automatic acquire(input int div);
        lock_req = 1'b0;
        step();
        rb_clkdiv = 3'(div);
        t_up      = 1'b0;
        t_down    = 1'b0;
        lock_req  = 1'b1;
        step();
        chk("init_code_valid", int'(code_valid), 0);
        step();
        period = 1 << (div + 3);
        model_reset();
        check_code("acq", 0);
        check_status("acq", 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int held;

        // up, dn, selflock, expected code, sat, dll_lock
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1};

        str_rst_n   = 1'b0;
        t_up        = 1'b0;
        t_down      = 1'b0;
        lock_req    = 1'b0;
        rb_clkdiv   = 3'd0;
        rb_selflock = 1'b0;
        period      = 8;
        model_reset();

        repeat (3) step();
        check_code("reset", 0);
        check_status("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk_pll);
        str_rst_n = 1'b1;
        repeat (3) step();
        check_status("idle_no_req", 1'b0, 1'b0, 1'b0);

        // Vector table
        acquire(0);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            run_tick(tbl[i].up, tbl[i].dn, tbl[i].sl, 8, held);
            check_code($sformatf("tbl%0d", i), tbl[i].code);
            check_status($sformatf("tbl%0d", i), tbl[i].sat, tbl[i].lock, 1'b1);
            held = tbl[i].code;
        end

        // Steady up from 0 for 100 ticks, then run to the top and saturate
        acquire(0);
        for (int k = 1; k <= 100; k++) begin
            model_step(1'b1, 1'b0, 1'b0);
            if (k == 5) chk("five_ticks_gry", int'(pvt_ref_gry), 7);
        end
        chk("after_100_code", int'(pvt_ref_gry), gray_of(100));
        chk("after_100_lock", int'(dll_lock), 0);
        for (int k = 101; k <= CODE_MAX; k++) model_step(1'b1, 1'b0, 1'b0);
        chk("reach_max", int'(pvt_ref_gry), gray_of(CODE_MAX));
        model_step(1'b0, 1'b1, 1'b0);
        model_step(1'b1, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 1'b0);
        chk("sat_at_max", int'(sat), 1);
        chk("sat_hold_code", int'(pvt_ref_gry), gray_of(CODE_MAX));
        model_step(1'b1, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, 1'b0);
        chk("sat_clear_on_hold", int'(sat), 0);
        model_step(1'b0, 1'b1, 1'b0);
        chk("no_lock_yet", int'(dll_lock), 0);
        model_step(1'b1, 1'b0, 1'b0);
        chk("lock_after_sat", int'(dll_lock), 1);

        // Frozen versus self-tracking lock
        for (int k = 0; k < 20; k++) model_step(1'b0, 1'b1, 1'b0);
        chk("frozen_code", int'(pvt_ref_gry), gray_of(CODE_MAX));
        for (int k = 0; k < 20; k++) model_step(1'b0, 1'b1, 1'b1);
        chk("selflock_code", int'(pvt_ref_gry), gray_of(CODE_MAX - 20));
        chk("selflock_lock", int'(dll_lock), 1);

        // Drop and re-raise lock_req
        lock_req = 1'b0;
        step();
        check_status("drop", 1'b0, 1'b0, 1'b0);
        check_code("drop", CODE_MAX - 20);
        repeat (3) step();
        chk("idle_retained", int'(pvt_ref_gry), gray_of(CODE_MAX - 20));
        lock_req = 1'b1;
        step();
        chk("reacq_init_valid", int'(code_valid), 0);
        step();
        check_code("reacq", 0);
        chk("reacq_valid", int'(code_valid), 1);

        // Divider select change lands at the following wrap
        acquire(0);
        model_step(1'b1, 1'b0, 1'b0);
        rb_clkdiv = 3'd1;
        model_step(1'b1, 1'b0, 1'b0);
        period = 16;
        model_step(1'b1, 1'b0, 1'b0);
        model_step(1'b0, 1'b1, 1'b0);

        // Randomized ticks against the model
        for (int seg = 0; seg < 3; seg++) begin
            acquire(int'($urandom_range(0, 2)));
            for (int k = 0; k < 60; k++)
                model_step(1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset between edges during tracking
        acquire(0);
        model_step(1'b1, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 1'b0);
        @(posedge clk_pll);
        #3;
        str_rst_n = 1'b0;
        #1;
        check_code("async_rst", 0);
        check_status("async_rst", 1'b0, 1'b0, 1'b0);
        lock_req = 1'b0;
        #2;
        str_rst_n = 1'b1;
        repeat (4) step();
        check_code("post_rst_idle", 0);
        check_status("post_rst_idle", 1'b0, 1'b0, 1'b0);
        acquire(0);
        model_step(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
